// File: rtl/hansen_mem_arbiter.sv
// Two-requester (core, PCIe) arbiter for a single-port synchronous RAM.
// Optional core anti-starvation counter enabled by defining HANSEN_ARB_STARVE_EN.
module hansen_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        core_req,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic        core_we,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,

    input  logic        pcie_req,
    input  logic [31:0] pcie_addr,
    input  logic [31:0] pcie_wdata,
    input  logic        pcie_we,
    output logic        pcie_gnt,
    output logic        pcie_rvalid,
    output logic [31:0] pcie_rdata,

    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_CORE = 2'b01,
        TAG_PCIE = 2'b10
    } read_tag_t;

    read_tag_t read_tag;
    logic      core_first;

`ifdef HANSEN_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!core_req || core_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign core_first = (starve_cnt >= LIMIT);
`else
    assign core_first = 1'b0;
`endif

    // Grants are masked during reset so no RAM access can start then.
    always_comb begin
        core_gnt = 1'b0;
        pcie_gnt = 1'b0;
        if (!reset) begin
            if (core_req && (!pcie_req || core_first)) begin
                core_gnt = 1'b1;
            end else if (pcie_req) begin
                pcie_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
        ram_we    = 1'b0;
        if (pcie_gnt) begin
            ram_addr  = pcie_addr;
            ram_wdata = pcie_wdata;
            ram_we    = pcie_we;
        end else if (core_gnt) begin
            ram_we    = core_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_tag <= TAG_NONE;
        end else if (core_gnt && !core_we) begin
            read_tag <= TAG_CORE;
        end else if (pcie_gnt && !pcie_we) begin
            read_tag <= TAG_PCIE;
        end else begin
            read_tag <= TAG_NONE;
        end
    end

    // The tag is the registered state; rvalid is a direct decode of it.
    assign core_rvalid = (read_tag == TAG_CORE);
    assign pcie_rvalid = (read_tag == TAG_PCIE);
    assign core_rdata  = ram_rdata;
    assign pcie_rdata  = ram_rdata;

    grant_onehot: assert property (@(posedge clk) disable iff (reset)
        !(core_gnt && pcie_gnt));

endmodule
